res_packer: RTL and testbench
=============================

# res_packer

Downstream consumer of the bfm result stream. Accepts one 8-bit result per handshake, packs four results little-endian into 32-bit words, buffers the words in a small FIFO and presents them on a valid/ready output. Keeps a running byte count and a 32-bit additive checksum of every accepted result. Asserts `done_o` once `LENGTH` results have been accepted and fully drained.

## Interface
- `LENGTH`, 2000000: number of results expected per run; triggers auto-flush and `done_o`.
- `DEPTH`, 8: word FIFO depth; power of two, at least 2.
- `clk_i`  in  1  single clock, all logic on rising edge.
- `reset_i`  in  1  reset, asynchronous, active-low.
- `res_valid_i`  in  1  result byte present.
- `res_i`  in  8  result byte.
- `res_ready_o`  out  1  byte accepted when `res_valid_i && res_ready_o`.
- `flush_i`  in  1  single-cycle pulse: emit the partial word now.
- `word_valid_o`  out  1  FIFO head valid.
- `word_o`  out  32  packed word; byte k in bits [8k+7:8k].
- `be_o`  out  4  byte enables of `word_o`. Lanes are filled from lane 0 upward.
- `word_ready_i`  in  1  sink pops the head when `word_valid_o && word_ready_i`.
- `byte_cnt_o`  out  32  accepted bytes, wraps modulo 2^32.
- `sum_o`  out  32  sum of zero-extended accepted bytes, wraps modulo 2^32.
- `done_o`  out  1  run complete, sticky until reset.

## Operation
- **Reset values:** all outputs 0, except `res_ready_o` = 1. Lane counter is 0, assembly register is 0, FIFO is empty, pending-flush flag is clear.
- **Ready rule:** `res_ready_o = !fifo_full && !done_o`. It is combinational from registered state only; it never depends on `res_valid_i`.
- **Byte accept:**
  - The byte is written to lane `lane_cnt` of the assembly register.
  - `lane_cnt` increments.
  - `byte_cnt_o` increments and `sum_o` adds the byte; both are updated on the same edge.
- **Word push:**
  - *Full word:* when the byte accepted fills lane 3, the completed word is pushed with `be` = 4'b1111. `lane_cnt` returns to 0.
  - *Flush:* when a flush is effective and `lane_cnt` > 0, a partial word is pushed with `be` = (1<<lane_cnt)-1 and unused lanes zero. `lane_cnt` returns to 0.
  - A flush with `lane_cnt` == 0 pushes nothing.
- **Flush and accept in the same cycle:** the byte is included first, then the flush is applied. If that byte completes lane 3, only the full word is pushed.
- **Flush while FIFO full:**
  - The flush is latched in the pending-flush flag.
  - It is applied in the first cycle the FIFO is not full.
  - No bytes are accepted meanwhile, because `res_ready_o` is low.
- **Auto-flush:** the cycle after `byte_cnt_o` reaches `LENGTH`, an internal flush is raised. It follows the same rules as `flush_i`.
- **Done:** `done_o` sets when all of the following hold; once set, `res_ready_o` stays 0:
  - `byte_cnt_o == LENGTH`,
  - `lane_cnt == 0`,
  - no pending flush,
  - FIFO empty.
- **FIFO:**
  - Show-ahead: the head is on `word_o`/`be_o` whenever `word_valid_o` = 1.
  - Push and pop in the same cycle are both honoured, and the count is unchanged.
  - A push never happens while full, which is guaranteed by the ready rule and the pending flag.
- **Reset mid-operation:** partial lanes, FIFO contents, counters and the pending flag are discarded. No word is emitted on reset.

## Timing
- **Latency:** the byte completing a word is accepted at edge N. The word is visible with `word_valid_o` = 1 after edge N, so the sink can pop at edge N+1.
- **Throughput:** one byte per cycle, i.e. one word every 4 cycles.
- **Flush latency:** `flush_i` high at edge N pushes the partial word at edge N; it is visible after edge N.
- **Auto-flush latency:** the last byte at edge N gives the auto-flush at edge N+1. `done_o` rises at the edge after the FIFO drains empty.
- **Output registering:** `byte_cnt_o` and `sum_o` are registered and reflect bytes accepted up to and including the previous edge.

## Structure
- Package `res_pkg`:
  - `word_t` (logic [31:0]),
  - `be_t` (logic [3:0]),
  - `LANES` = 4,
  - the lane-to-byte-enable function.
- Sub-module `res_fifo`:
  - parameterised synchronous show-ahead FIFO of {be, word},
  - ports: push/pop, full/empty and count,
  - async active-low reset on `reset_i`.
- Top level holds the lane counter, assembly register, pending flag, counters, checksum and done logic.

## Test plan
- **Full words:** push bytes 0x01..0x08 with sink always ready -> words 0x04030201 then 0x08070605, `be` = 4'hF. `sum_o` = 36, `byte_cnt_o` = 8.
- **Manual flush:** push 0xAA, 0xBB, then pulse `flush_i` -> word 0x0000BBAA with `be` = 4'h3; `lane_cnt` back to 0.
- **Backpressure:**
  - `DEPTH` = 2, sink stalled, stream 12 bytes.
  - `res_ready_o` drops after byte 8 and no data is lost.
  - Releasing the sink yields all 3 words in order.
- **Flush while full:**
  - With `DEPTH` = 2, hold the sink and fill the FIFO, then pulse `flush_i` with 1 byte (0x5A) in lanes.
  - The partial word 0x0000005A with `be` = 4'h1 appears only after the first pop.
- **Auto-flush and done:**
  - `LENGTH` = 6, bytes 0xFF x6.
  - Expect word 0xFFFFFFFF (`be` = 4'hF), then 0x0000FFFF (`be` = 4'h3).
  - `sum_o` = 0x5FA; `done_o` rises after the drain and `res_ready_o` = 0.
- **Reset mid-word:** deassert `reset_i` asynchronously after 3 bytes -> all outputs at reset values immediately; the next 4 bytes form a clean word.

Source files
------------

// File: rtl/res_pkg.sv
// Shared types, constants and the lane-count to byte-enable helper for the
// result packer.
package res_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  typedef struct packed {
    be_t   be;
    word_t word;
  } entry_t;

  localparam int LANES = 4;

  // Byte enables for a word holding n bytes, filled from lane 0 upward.
  function automatic be_t lane_be(input logic [2:0] n);
    be_t be;
    case (n)
      3'd0:    be = 4'b0000;
      3'd1:    be = 4'b0001;
      3'd2:    be = 4'b0011;
      3'd3:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/res_fifo.sv
// Show-ahead synchronous FIFO of {be, word} entries. The head is presented
// combinationally from storage and reads as zero while the FIFO is empty.
module res_fifo
  import res_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign full  = (cnt == (AW + 1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/res_packer.sv
// Packs accepted result bytes little-endian into 32-bit words, queues them in
// a small FIFO, and tracks byte count, checksum and end-of-run completion.
module res_packer
  import res_pkg::*;
#(
  parameter int LENGTH = 2000000,
  parameter int DEPTH  = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        res_valid_i,
  input  logic [7:0]  res_i,
  output logic        res_ready_o,
  input  logic        flush_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [3:0]  be_o,
  input  logic        word_ready_i,
  output logic [31:0] byte_cnt_o,
  output logic [31:0] sum_o,
  output logic        done_o
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LEN32 = 32'(LENGTH);

  logic [1:0]  lane_cnt;
  word_t       asm_word;
  logic        pend_flush;
  logic        auto_flush;
  logic        done;
  logic [31:0] byte_cnt;
  logic [31:0] sum;

  logic        accept;
  logic        flush_req;
  logic        full_push;
  logic        flush_push;
  logic        push;
  logic        pop;
  logic [2:0]  lane_fill;
  word_t       word_fill;
  entry_t      push_entry;
  entry_t      head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;

  assign res_ready_o = !fifo_full && !done;
  assign accept      = res_valid_i && res_ready_o;
  assign pop         = !fifo_empty && word_ready_i;
  assign flush_req   = flush_i || auto_flush || pend_flush;

  // Merge the incoming byte first, then decide whether a full or flushed word leaves.
  always_comb begin
    lane_fill  = {1'b0, lane_cnt};
    word_fill  = asm_word;
    if (accept) begin
      word_fill[{lane_cnt, 3'b000} +: 8] = res_i;
      lane_fill                          = {1'b0, lane_cnt} + 3'd1;
    end else begin
      word_fill = asm_word;
    end
    full_push  = (lane_fill == 3'd4);
    flush_push = flush_req && !fifo_full && !full_push && (lane_fill != 3'd0);
    push       = full_push || flush_push;
    push_entry = '{be: lane_be(lane_fill), word: word_fill};
  end

  // Lane assembly, counters, pending flush and sticky completion.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      lane_cnt   <= 2'd0;
      asm_word   <= '0;
      pend_flush <= 1'b0;
      auto_flush <= 1'b0;
      done       <= 1'b0;
      byte_cnt   <= 32'd0;
      sum        <= 32'd0;
    end else begin
      if (push) begin
        lane_cnt <= 2'd0;
        asm_word <= '0;
      end else begin
        lane_cnt <= lane_fill[1:0];
        asm_word <= word_fill;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 32'd1;
        sum      <= sum + {24'd0, res_i};
      end
      auto_flush <= accept && (byte_cnt + 32'd1 == LEN32);
      // A flush seen while full waits for the first non-full cycle.
      if (flush_req && fifo_full) begin
        pend_flush <= 1'b1;
      end else if (flush_req) begin
        pend_flush <= 1'b0;
      end
      if ((byte_cnt == LEN32) && (lane_cnt == 2'd0) && !pend_flush && (fifo_count == '0)) begin
        done <= 1'b1;
      end
    end
  end

  res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign word_valid_o = !fifo_empty;
  assign word_o       = head.word;
  assign be_o         = head.be;
  assign byte_cnt_o   = byte_cnt;
  assign sum_o        = sum;
  assign done_o       = done;

endmodule

// File: tb/tb_res_packer.sv
// Scoreboard bench for res_packer: two instances (DEPTH 2 / LENGTH 200 and
// DEPTH 8 / LENGTH 6) share stimulus, each with its own queue-based model.
module tb_res_packer;

  localparam int NDUT = 2;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic       res_valid  = 1'b0;
  logic [7:0] res_data   = 8'd0;
  logic       flush      = 1'b0;
  logic       sink_ready = 1'b0;

  logic        rdy  [NDUT];
  logic        wv   [NDUT];
  logic [31:0] wd   [NDUT];
  logic [3:0]  wbe  [NDUT];
  logic [31:0] bcnt [NDUT];
  logic [31:0] sumv [NDUT];
  logic        dn   [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", name, d, act, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : mdl
    localparam int LEN = (g == 0) ? 200 : 6;
    localparam int DEP = (g == 0) ? 2 : 8;

    res_packer #(.LENGTH(LEN), .DEPTH(DEP)) dut (
      .clk_i        (clk),
      .reset_i      (reset_n),
      .res_valid_i  (res_valid),
      .res_i        (res_data),
      .res_ready_o  (rdy[g]),
      .flush_i      (flush),
      .word_valid_o (wv[g]),
      .word_o       (wd[g]),
      .be_o         (wbe[g]),
      .word_ready_i (sink_ready),
      .byte_cnt_o   (bcnt[g]),
      .sum_o        (sumv[g]),
      .done_o       (dn[g])
    );

    logic [35:0] exp_q [$];
    logic [7:0]  lanes [$];
    int          cnt;
    logic [31:0] bc;
    logic [31:0] sm;
    logic        pend;
    logic        autof;
    logic        done_m;

    // Reference model: checks visible state, then predicts the next edge.
    always @(negedge clk) begin : step
      logic        acc;
      logic        emit;
      logic        done_cond;
      logic [31:0] w;
      logic [3:0]  be_v;
      int          pushes;
      if (!reset_n) begin
        chk("rst_ready", g, 32'(rdy[g]), 32'd1);
        chk("rst_valid", g, 32'(wv[g]), 32'd0);
        chk("rst_word", g, wd[g], 32'd0);
        chk("rst_be", g, 32'(wbe[g]), 32'd0);
        chk("rst_bcnt", g, bcnt[g], 32'd0);
        chk("rst_sum", g, sumv[g], 32'd0);
        chk("rst_done", g, 32'(dn[g]), 32'd0);
        exp_q.delete();
        lanes.delete();
        cnt = 0; bc = 32'd0; sm = 32'd0; pend = 1'b0; autof = 1'b0; done_m = 1'b0;
      end else begin
        chk("ready", g, 32'(rdy[g]), 32'((cnt < DEP) && !done_m));
        chk("valid", g, 32'(wv[g]), 32'(cnt > 0));
        chk("bcnt", g, bcnt[g], bc);
        chk("sum", g, sumv[g], sm);
        chk("done", g, 32'(dn[g]), 32'(done_m));
        done_cond = (bc == 32'(LEN)) && (lanes.size() == 0) && !pend && (cnt == 0);
        acc = res_valid && (cnt < DEP) && !done_m;
        pushes = 0;
        if (acc) begin
          lanes.push_back(res_data);
          bc = bc + 32'd1;
          sm = sm + {24'd0, res_data};
        end
        emit = (lanes.size() == 4);
        if (flush || autof || pend) begin
          if (cnt == DEP) pend = 1'b1;
          else begin
            pend = 1'b0;
            if (lanes.size() > 0) emit = 1'b1;
          end
        end
        if (emit) begin
          w = 32'd0;
          for (int i = 0; i < lanes.size(); i++) w[8*i +: 8] = lanes[i];
          be_v = 4'((1 << lanes.size()) - 1);
          exp_q.push_back({be_v, w});
          lanes.delete();
          pushes = 1;
        end
        autof = acc && (bc == 32'(LEN));
        if (sink_ready && cnt > 0) cnt--;
        cnt += pushes;
        if (done_cond) done_m = 1'b1;
      end
    end

    // Monitor: every popped word must match the oldest expected word.
    always @(negedge clk) begin : mon
      logic [35:0] e;
      if (reset_n && wv[g] && sink_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word dut%0d: got %h/%h want none", g, wbe[g], wd[g]);
        end else begin
          e = exp_q.pop_front();
          chk("word", g, wd[g], e[31:0]);
          chk("be", g, 32'(wbe[g]), 32'(e[35:32]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; res_valid = 1'b0; flush = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  // Present one byte until instance 0 takes it, with a bounded wait.
  task automatic send(input logic [7:0] b);
    logic taken;
    taken = 1'b0;
    res_valid = 1'b1;
    res_data  = b;
    for (int t = 0; t < 40 && !taken; t++) begin
      @(negedge clk);
      taken = rdy[0];
      cyc();
    end
    res_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h got stalled want accepted", b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Full words.
    sink_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i));
    repeat (4) cyc();
    chk("fw_sum", 0, sumv[0], 32'd36);
    chk("fw_bcnt", 0, bcnt[0], 32'd8);

    // Manual flush, then a clean word.
    do_reset();
    send(8'hAA); send(8'hBB);
    flush = 1'b1; cyc(); flush = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i));
    repeat (4) cyc();
    chk("mf_bcnt", 0, bcnt[0], 32'd6);

    // Backpressure with the sink stalled.
    do_reset();
    sink_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(8'h40 + i));
    res_valid = 1'b1; res_data = 8'h49;
    repeat (4) cyc();
    chk("bp_ready", 0, 32'(rdy[0]), 32'd0);
    chk("bp_bcnt", 0, bcnt[0], 32'd8);
    sink_ready = 1'b1;
    for (int i = 9; i <= 12; i++) send(8'(8'h40 + i));
    repeat (6) cyc();
    chk("bp_bcnt_end", 0, bcnt[0], 32'd12);

    // Flush while full: partial word only after the first pop.
    do_reset();
    sink_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    res_valid = 1'b1; res_data = 8'h5A;
    flush = 1'b1; cyc(); flush = 1'b0;
    repeat (3) cyc();
    chk("ff_bcnt_hold", 0, bcnt[0], 32'd8);
    chk("ff_ready", 0, 32'(rdy[0]), 32'd0);
    sink_ready = 1'b1; cyc(); sink_ready = 1'b0;
    cyc();
    res_valid = 1'b0;
    chk("ff_bcnt", 0, bcnt[0], 32'd9);
    sink_ready = 1'b1;
    repeat (6) cyc();

    // Auto-flush and done on the LENGTH=6 instance.
    do_reset();
    for (int i = 0; i < 6; i++) send(8'hFF);
    repeat (8) cyc();
    chk("af_sum", 1, sumv[1], 32'h5FA);
    chk("af_bcnt", 1, bcnt[1], 32'd6);
    chk("af_done", 1, 32'(dn[1]), 32'd1);
    chk("af_ready", 1, 32'(rdy[1]), 32'd0);

    // Asynchronous reset mid-word.
    do_reset();
    send(8'h01); send(8'h02); send(8'h03);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("ar_bcnt", d, bcnt[d], 32'd0);
      chk("ar_sum", d, sumv[d], 32'd0);
      chk("ar_ready", d, 32'(rdy[d]), 32'd1);
      chk("ar_valid", d, 32'(wv[d]), 32'd0);
    end
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h21 + i));
    repeat (4) cyc();
    chk("ar_bcnt_after", 0, bcnt[0], 32'd4);

    // Randomized traffic, then drain.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      res_valid  = ($urandom % 4) != 0;
      res_data   = 8'($urandom);
      flush      = ($urandom % 12) == 0;
      sink_ready = ($urandom % 3) != 0;
      cyc();
    end
    res_valid = 1'b0; flush = 1'b0; sink_ready = 1'b1;
    repeat (20) cyc();
    chk("drain_q", 0, 32'(mdl[0].exp_q.size()), 32'd0);
    chk("drain_q", 1, 32'(mdl[1].exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
